// File: rtl/contrast_frame_ctrl_pkg.sv
// contrast_frame_ctrl_pkg: pixel/contrast types and frame sequencer state encoding
package contrast_frame_ctrl_pkg;

   typedef logic [7:0] color_t;
   typedef logic [7:0] contrast_fp_t;

   typedef enum logic [2:0] {IDLE, LOAD, CHECK, STREAM, DRAIN, DONE} ctrl_state_t;

endpackage

// File: rtl/contrast_frame_ctrl_pix_skid_fifo.sv
// pix_skid_fifo: small output FIFO absorbing pixels leaving the non-stallable datapath
module pix_skid_fifo
   import contrast_frame_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         push,
   input  color_t                       din,
   input  logic                         pop,
   output color_t                       dout,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   color_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_pop;

   assign empty  = count == '0;
   assign full   = count == CW'(DEPTH);
   assign do_pop = pop && !empty;
   assign dout   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr == AW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr == AW'(DEPTH-1) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(do_pop);
      end
   end

   // the upstream credit scheme must make a push into a full FIFO impossible
   a_no_overflow: assert property (@(posedge clk) disable iff (!resetN) !(push && full && !pop));

endmodule

// File: rtl/contrast_frame_ctrl.sv
// contrast_frame_ctrl: applies shadowed contrast config at frame start, then streams
// height*width pixels through the contrast datapath into an output skid FIFO.
module contrast_frame_ctrl
   import contrast_frame_ctrl_pkg::*;
#(
   parameter int DP_LAT     = 1,
   parameter int LUT_SETTLE = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int DIM_W      = 12
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               cfg_wr,
   input  logic               cfg_en_cp,
   input  contrast_fp_t       cfg_contrast_fp,
   input  logic [DIM_W-1:0]   img_height,
   input  logic [DIM_W-1:0]   img_width,
   input  logic               sof,
   input  color_t             pix_in,
   input  logic               pix_in_valid,
   output logic               pix_in_ready,
   output logic               lut_en_cp,
   output contrast_fp_t       lut_contrast_fp,
   input  logic               lut_invalid,
   output color_t             dp_color_in,
   input  color_t             dp_color_out,
   output color_t             pix_out,
   output logic               pix_out_valid,
   input  logic               pix_out_ready,
   output logic               busy,
   output logic               frame_done,
   output logic               sof_drop,
   output logic               cfg_err
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = LUT_SETTLE > 1 ? $clog2(LUT_SETTLE) : 1;

   ctrl_state_t state;
   logic sh_en;
   contrast_fp_t sh_fp;
   logic [2*DIM_W-1:0] size, remaining;
   logic [SW-1:0] settle;
   // bit 0 tracks the pixel sitting in dp_color_in, bit DP_LAT the one now valid on dp_color_out
   logic [DP_LAT:0] sr;
   logic [CW-1:0] fifo_count;
   logic fifo_empty, fifo_full, xfer, push, pop;
   int inflight;

   assign inflight      = $countones(sr);
   assign pix_in_ready  = state == STREAM && remaining != '0 && !fifo_full &&
                          int'(fifo_count) + inflight < FIFO_DEPTH;
   assign xfer          = pix_in_valid && pix_in_ready;
   assign push          = sr[DP_LAT];
   assign pix_out_valid = !fifo_empty;
   assign pop           = pix_out_valid && pix_out_ready;
   assign busy          = state != IDLE;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state           <= IDLE;
         sh_en           <= 1'b0;
         sh_fp           <= '0;
         size            <= '0;
         remaining       <= '0;
         settle          <= '0;
         sr              <= '0;
         lut_en_cp       <= 1'b0;
         lut_contrast_fp <= '0;
         dp_color_in     <= '0;
         frame_done      <= 1'b0;
         sof_drop        <= 1'b0;
         cfg_err         <= 1'b0;
      end else begin
         if (cfg_wr) begin
            sh_en <= cfg_en_cp;
            sh_fp <= cfg_contrast_fp;
         end
         sr         <= {sr[DP_LAT-1:0], xfer};
         sof_drop   <= sof && state != IDLE;
         frame_done <= 1'b0;
         cfg_err    <= cfg_wr ? 1'b0 : cfg_err;
         if (xfer) dp_color_in <= pix_in;
         case (state)
            IDLE: if (sof) begin
               size            <= {{DIM_W{1'b0}}, img_height} * {{DIM_W{1'b0}}, img_width};
               lut_en_cp       <= sh_en;
               lut_contrast_fp <= sh_fp;
               settle          <= '0;
               state           <= LOAD;
            end
            LOAD: begin
               settle <= settle + 1'b1;
               if (settle == SW'(LUT_SETTLE - 1)) state <= CHECK;
            end
            CHECK: begin
               if (lut_invalid) begin
                  cfg_err   <= 1'b1;
                  lut_en_cp <= 1'b0;
               end
               remaining  <= size;
               state      <= size == '0 ? DONE : STREAM;
               frame_done <= size == '0;
            end
            STREAM: begin
               if (xfer) remaining <= remaining - 1'b1;
               if (remaining == '0) state <= DRAIN;
            end
            DRAIN: if (sr == '0 && fifo_empty) begin
               state      <= DONE;
               frame_done <= 1'b1;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   pix_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .resetN (resetN),
      .push   (push),
      .din    (dp_color_out),
      .pop    (pop),
      .dout   (pix_out),
      .count  (fifo_count),
      .empty  (fifo_empty),
      .full   (fifo_full)
   );

endmodule

// File: tb/tb_contrast_frame_ctrl.sv
// tb_contrast_frame_ctrl: frame table plus reset corner case, with a behavioural
// contrast datapath and an expected-pixel scoreboard queue.
module tb_contrast_frame_ctrl;
   import contrast_frame_ctrl_pkg::*;

   localparam int DP_LAT = 1;
   localparam int FIFO_DEPTH = 4;

   logic clk = 1'b0, resetN = 1'b0;
   logic cfg_wr = 1'b0, cfg_en_cp = 1'b0, sof = 1'b0, pix_in_valid = 1'b0, pix_out_ready = 1'b1;
   logic lut_invalid = 1'b0;
   contrast_fp_t cfg_contrast_fp = '0;
   logic [11:0] img_height = '0, img_width = '0;
   color_t pix_in = '0;
   logic pix_in_ready, lut_en_cp, pix_out_valid, busy, frame_done, sof_drop, cfg_err;
   contrast_fp_t lut_contrast_fp;
   color_t dp_color_in, dp_color_out, pix_out;

   always #5 clk = ~clk;

   contrast_frame_ctrl #(.DP_LAT(DP_LAT), .LUT_SETTLE(4), .FIFO_DEPTH(FIFO_DEPTH), .DIM_W(12)) dut (
      .clk(clk), .resetN(resetN), .cfg_wr(cfg_wr), .cfg_en_cp(cfg_en_cp),
      .cfg_contrast_fp(cfg_contrast_fp), .img_height(img_height), .img_width(img_width),
      .sof(sof), .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
      .lut_en_cp(lut_en_cp), .lut_contrast_fp(lut_contrast_fp), .lut_invalid(lut_invalid),
      .dp_color_in(dp_color_in), .dp_color_out(dp_color_out), .pix_out(pix_out),
      .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready), .busy(busy),
      .frame_done(frame_done), .sof_drop(sof_drop), .cfg_err(cfg_err)
   );

   function automatic color_t gold(input color_t c, input contrast_fp_t fp);
      logic [15:0] p;
      p = (16'(c) * 16'(fp)) >> 4;
      return p > 16'd255 ? 8'hff : p[7:0];
   endfunction

   // behavioural contrast datapath: DP_LAT register stages
   color_t pipe [DP_LAT];
   always @(posedge clk) begin
      pipe[0] <= lut_en_cp ? gold(dp_color_in, lut_contrast_fp) : dp_color_in;
      for (int i = 1; i < DP_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign dp_color_out = pipe[DP_LAT-1];

   int n_vec = 0, n_bad = 0, n_out = 0;
   color_t q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (resetN && pix_out_valid && pix_out_ready) begin
         n_out++;
         if (q.size() == 0) check("unexpected_pix", 32'(pix_out), 32'hffff_ffff);
         else check("pix", 32'(pix_out), 32'(q.pop_front()));
      end
   end

   typedef struct {
      logic wr; logic en; logic [7:0] fp; logic inv; int h; int w; int bp_at; int bp_len;
      logic mid_cfg; logic [7:0] mid_fp; logic sof_mid;
      logic exp_en; logic [7:0] exp_fp; logic exp_err;
   } frame_t;

   frame_t tbl [6];
   logic sh_en = 1'b0;
   logic [7:0] sh_fp = '0;

   function automatic color_t pat(input int f, input int i);
      int v;
      v = i * 37 + f * 11 + 5;
      return v[7:0];
   endfunction

   task automatic run_frame(input int f, input frame_t r);
      int n, sent, k, nd, done_at;
      logic eff_en, rdy_seen, sof_done, cfg_done, sof_chk;
      logic [7:0] eff_fp;
      n = r.h * r.w;
      n_out = 0; sent = 0; k = 0; nd = 0; done_at = -1;
      rdy_seen = 0; sof_done = 0; cfg_done = 0; sof_chk = 0;
      if (r.wr) begin
         @(negedge clk);
         cfg_wr = 1'b1; cfg_en_cp = r.en; cfg_contrast_fp = r.fp;
         sh_en = r.en; sh_fp = r.fp;
      end
      @(negedge clk);
      cfg_wr = 1'b0;
      lut_invalid = r.inv;
      img_height = 12'(r.h); img_width = 12'(r.w);
      sof = 1'b1;
      #2;
      if (r.wr) check("cfg_err_clr", 32'(cfg_err), 0);
      eff_en = sh_en && !r.inv;
      eff_fp = sh_fp;
      @(negedge clk);
      sof = 1'b0;
      #2;
      check("lut_fp_load", 32'(lut_contrast_fp), 32'(r.exp_fp));
      check("busy_load", 32'(busy), 1);
      while (sent < n && k < 1000) begin
         @(negedge clk);
         sof = 1'b0; cfg_wr = 1'b0;
         pix_in = pat(f, sent); pix_in_valid = 1'b1;
         pix_out_ready = !(sent > 0 && k >= r.bp_at && k < r.bp_at + r.bp_len);
         if (r.sof_mid && !sof_done && sent == 3) begin sof = 1'b1; sof_done = 1; end
         if (r.mid_cfg && !cfg_done && sent == 5) begin
            cfg_wr = 1'b1; cfg_en_cp = 1'b1; cfg_contrast_fp = r.mid_fp;
            sh_en = 1'b1; sh_fp = r.mid_fp; cfg_done = 1;
         end
         #2;
         if (sof_chk) begin check("sof_drop", 32'(sof_drop), 1); sof_chk = 0; end
         if (sof) sof_chk = 1;
         if (!pix_out_ready)
            check("ready_credit", 32'(pix_in_ready), 32'(q.size() < FIFO_DEPTH));
         if (pix_in_ready) begin
            q.push_back(eff_en ? gold(pat(f, sent), eff_fp) : pat(f, sent));
            sent++;
         end
         k++;
      end
      check("sent", 32'(sent), 32'(n));
      @(negedge clk);
      pix_in_valid = 1'b0; pix_out_ready = 1'b1; sof = 1'b0; cfg_wr = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         #2;
         if (pix_in_ready) rdy_seen = 1;
         if (done_at >= 0) begin
            check("busy_fall", 32'(busy), 0);
            check("done_pulse", 32'(frame_done), 0);
            break;
         end
         if (frame_done) begin nd++; done_at = c; end
      end
      check("frame_done", 32'(nd), 1);
      check("npix", 32'(n_out), 32'(n));
      check("queue_empty", 32'(q.size()), 0);
      check("lut_en", 32'(lut_en_cp), 32'(r.exp_en));
      check("lut_fp", 32'(lut_contrast_fp), 32'(r.exp_fp));
      check("cfg_err", 32'(cfg_err), 32'(r.exp_err));
      if (n == 0) check("no_ready", 32'(rdy_seen), 0);
      lut_invalid = 1'b0;
   endtask

   initial begin
      //           wr    en    fp     inv   h  w  bpa bpl mid   midfp  sofm  xen   xfp    xerr
      tbl[0] = '{1'b1, 1'b1, 8'h04, 1'b0, 4, 4, 0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 4, 4, 2, 6, 1'b1, 8'h08, 1'b0, 1'b1, 8'h04, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 4, 4, 0, 0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 8'h20, 1'b1, 4, 4, 1, 3, 1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 1'b1};
      tbl[4] = '{1'b1, 1'b1, 8'h06, 1'b0, 4, 0, 0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h06, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 8'h18, 1'b0, 3, 5, 4, 5, 1'b0, 8'h00, 1'b0, 1'b1, 8'h18, 1'b0};

      repeat (3) @(negedge clk);
      #2;
      check("rst_outs", 32'({pix_in_ready, pix_out_valid, busy, frame_done, sof_drop, cfg_err, lut_en_cp}), 0);
      check("rst_lut_fp", 32'(lut_contrast_fp), 0);
      check("rst_dp_in", 32'(dp_color_in), 0);
      resetN = 1'b1;

      for (int i = 0; i < 5; i++) run_frame(i, tbl[i]);

      // reset in the middle of a stream with pixels held in the FIFO
      begin
         int sent, nd;
         sent = 0; nd = 0;
         @(negedge clk);
         cfg_wr = 1'b1; cfg_en_cp = 1'b1; cfg_contrast_fp = 8'h0c;
         @(negedge clk);
         cfg_wr = 1'b0; img_height = 12'd4; img_width = 12'd4; sof = 1'b1;
         @(negedge clk);
         sof = 1'b0; pix_out_ready = 1'b0; pix_in_valid = 1'b1;
         for (int c = 0; c < 40 && sent < 3; c++) begin
            @(negedge clk);
            pix_in = pat(9, sent);
            #2;
            if (pix_in_ready) begin q.push_back(gold(pat(9, sent), 8'h0c)); sent++; end
         end
         check("mid_sent", 32'(sent), 3);
         @(negedge clk);
         resetN = 1'b0; pix_in_valid = 1'b0;
         @(negedge clk);
         #2;
         check("mrst_busy", 32'(busy), 0);
         check("mrst_valid", 32'(pix_out_valid), 0);
         check("mrst_ready", 32'(pix_in_ready), 0);
         check("mrst_lut", 32'({lut_en_cp, lut_contrast_fp}), 0);
         resetN = 1'b1; pix_out_ready = 1'b1;
         q.delete();
         sh_en = 1'b0; sh_fp = '0;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #2;
            if (frame_done || pix_out_valid || busy) nd++;
         end
         check("mrst_quiet", 32'(nd), 0);
      end

      run_frame(5, tbl[5]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
